// File: rtl/fetch_sequencer.sv
// Instruction fetch and control-flow stage: drives the ROM address, registers the
// fetched word, resolves JMP/CALL/RET/BLE and keeps a hardware return-address stack.
module fetch_sequencer #(
    parameter int unsigned STACK_DEPTH = 8,
    parameter logic [3:0]  OP_JMP      = 4'd1,
    parameter logic [3:0]  OP_CALL     = 4'd2,
    parameter logic [3:0]  OP_RET      = 4'd3,
    parameter logic [3:0]  OP_BLE      = 4'd4,
    parameter logic [27:0] NOP_WORD    = 28'h0
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic                           iStall,
    input  logic [27:0]                    iInstruction,
    input  logic                           iBranchTaken,
    output logic [15:0]                    oAddress,
    output logic [27:0]                    oInstruction,
    output logic [15:0]                    oInstrPC,
    output logic                           oValid,
    output logic [$clog2(STACK_DEPTH):0]   oStackDepth,
    output logic                           oStackError
);

    localparam int unsigned SPW = $clog2(STACK_DEPTH);
    localparam int unsigned DW  = SPW + 1;

    logic [15:0]    pc;
    logic [15:0]    stack [STACK_DEPTH];
    logic [DW-1:0]  sp;

    logic [3:0]     opcode;
    logic [15:0]    target;
    logic [15:0]    redirect_pc;
    logic [SPW-1:0] top_idx;
    logic [SPW-1:0] push_idx;
    logic           full;
    logic           empty;
    logic           is_jmp;
    logic           is_call;
    logic           is_ret;
    logic           is_ble;
    logic           do_push;
    logic           do_pop;
    logic           err_set;
    logic           taken;

    // Control-flow decision on the decode register; bubbles never decide.
    always_comb begin
        opcode      = oInstruction[27:24];
        target      = {8'h00, oInstruction[23:16]};
        full        = (sp == DW'(STACK_DEPTH));
        empty       = (sp == '0);
        top_idx     = SPW'(sp - DW'(1));
        push_idx    = SPW'(sp);
        is_jmp      = oValid && (opcode == OP_JMP);
        is_call     = oValid && (opcode == OP_CALL);
        is_ret      = oValid && (opcode == OP_RET);
        is_ble      = oValid && (opcode == OP_BLE);
        do_push     = is_call && !full;
        do_pop      = is_ret && !empty;
        err_set     = (is_call && full) || (is_ret && empty);
        // An underflowing RET is a plain fall-through, so only a real pop redirects.
        taken       = is_jmp || is_call || do_pop || (is_ble && iBranchTaken);
        redirect_pc = do_pop ? stack[top_idx] : target;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc           <= 16'h0000;
            oInstruction <= NOP_WORD;
            oInstrPC     <= 16'h0000;
            oValid       <= 1'b0;
            sp           <= '0;
            oStackError  <= 1'b0;
        end else if (!iStall) begin
            if (taken) begin
                pc           <= redirect_pc;
                oInstruction <= NOP_WORD;
                oValid       <= 1'b0;
            end else begin
                pc           <= pc + 16'd1;
                oInstruction <= iInstruction;
                oValid       <= 1'b1;
            end
            oInstrPC <= pc;
            if (do_push) begin
                sp <= sp + DW'(1);
            end else if (do_pop) begin
                sp <= sp - DW'(1);
            end
            if (err_set) begin
                oStackError <= 1'b1;
            end
        end
    end

    // Return-address storage; contents are only meaningful below sp.
    always_ff @(posedge Clock) begin
        if (!Reset && !iStall && do_push) begin
            stack[push_idx] <= oInstrPC + 16'd1;
        end
    end

    assign oAddress    = pc;
    assign oStackDepth = sp;

endmodule
